// File: rtl/alu_sequencer.sv
// alu_sequencer: hardwired fetch/decode/execute control FSM driving the ALU/register datapath.
// Build option SEQ_ILLEGAL_TRAP_EN: an undefined opcode halts the sequencer instead of acting as NOP.
module alu_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] ins,
    input  logic       j_in,
    output logic [4:0] C,
    output logic [1:0] B,
    output logic [1:0] M,
    output logic [3:0] ALU_sig,
    output logic       JAMZ,
    output logic       set_F,
    output logic       ins_fetch,
    output logic       busy,
    output logic       halted,
    output logic       illegal,
    output logic [2:0] state_o,
    output logic [7:0] ir_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t     state_q;
    logic [7:0] ir_q;
    logic [3:0] cnt_q;
    logic       mem_q, ld_q, stop_q;
    logic [4:0] c_q;
    logic [1:0] b_q, m_q;
    logic [3:0] alu_q;
    logic       jamz_q, setf_q, fetch_q, busy_q, halted_q, illegal_q;

    logic [4:0] c_d;
    logic [1:0] b_d;
    logic [3:0] alu_d;
    logic       jamz_d, setf_d, mem_d, ld_d, halt_d, ill_d, stop_d;
    logic       jz_take;

    // ins is valid during DECODE (one cycle after ins_fetch); there is no back-pressure,
    // so the byte is decoded here and the EXEC controls are registered on that edge.
    always_comb begin
        c_d    = '0;
        b_d    = '0;
        alu_d  = '0;
        jamz_d = 1'b0;
        setf_d = 1'b0;
        mem_d  = 1'b0;
        ld_d   = 1'b0;
        halt_d = 1'b0;
        ill_d  = 1'b0;
        case (ins[7:4])
            4'h0: ;
            4'h1: begin c_d = 5'b01000; b_d = 2'b11; alu_d = 4'd4; mem_d = 1'b1; ld_d = 1'b1; end
            4'h2: begin c_d = 5'b01000; b_d = 2'b11; alu_d = 4'd4; mem_d = 1'b1; end
            4'h3: begin c_d = 5'b00001; alu_d = 4'd1; setf_d = 1'b1; end
            4'h4: begin c_d = 5'b00001; alu_d = 4'd2; setf_d = 1'b1; end
            4'h5: begin c_d = 5'b00001; alu_d = 4'd3; setf_d = 1'b1; end
            4'h6: begin c_d = 5'b00010; alu_d = 4'd0; end
            4'h7: begin c_d = 5'b10000; b_d = 2'b11; alu_d = 4'd4; end
            4'h8: jamz_d = 1'b1;
            4'hF: halt_d = 1'b1;
            default: ill_d = 1'b1;
        endcase
`ifdef SEQ_ILLEGAL_TRAP_EN
        stop_d = halt_d | ill_d;
`else
        stop_d = halt_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            cnt_q     <= '0;
            mem_q     <= 1'b0;
            ld_q      <= 1'b0;
            stop_q    <= 1'b0;
            c_q       <= '0;
            b_q       <= '0;
            m_q       <= '0;
            alu_q     <= '0;
            jamz_q    <= 1'b0;
            setf_q    <= 1'b0;
            fetch_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            c_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            alu_q   <= '0;
            jamz_q  <= 1'b0;
            setf_q  <= 1'b0;
            fetch_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_FETCH;
                        busy_q  <= 1'b1;
                        fetch_q <= 1'b1;
                        c_q     <= 5'b10000;
                        alu_q   <= 4'd5;
                    end
                end
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    state_q <= S_EXEC;
                    ir_q    <= ins;
                    c_q     <= c_d;
                    b_q     <= b_d;
                    alu_q   <= alu_d;
                    jamz_q  <= jamz_d;
                    setf_q  <= setf_d;
                    mem_q   <= mem_d;
                    ld_q    <= ld_d;
                    stop_q  <= stop_d;
                    if (ill_d) illegal_q <= 1'b1;
                end
                S_EXEC: begin
                    if (stop_q) begin
                        state_q  <= S_HALT;
                        busy_q   <= 1'b0;
                        halted_q <= 1'b1;
                    end else if (mem_q) begin
                        state_q <= S_MEM;
                        cnt_q   <= 4'(MEM_WAIT - 1);
                        m_q     <= ld_q ? 2'b10 : 2'b01;
                        // AC takes the read data through the ALU in pass-B mode on the last strobe cycle
                        if (ld_q && MEM_WAIT == 1) begin
                            c_q   <= 5'b00001;
                            b_q   <= 2'b10;
                            alu_q <= 4'd4;
                        end
                    end else begin
                        state_q <= S_FETCH;
                        fetch_q <= 1'b1;
                        c_q     <= 5'b10000;
                        alu_q   <= 4'd5;
                    end
                end
                S_MEM: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_FETCH;
                        fetch_q <= 1'b1;
                        c_q     <= 5'b10000;
                        alu_q   <= 4'd5;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                        m_q   <= m_q;
                        if (ld_q && cnt_q == 4'd1) begin
                            c_q   <= 5'b00001;
                            b_q   <= 2'b10;
                            alu_q <= 4'd4;
                        end
                    end
                end
                S_HALT: ;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // JZ resolves against the live flag-unit result during EXEC
    assign jz_take   = jamz_q & j_in;
    assign C         = jz_take ? 5'b10000 : c_q;
    assign B         = jz_take ? 2'b11 : b_q;
    assign ALU_sig   = jz_take ? 4'd4 : alu_q;
    assign M         = m_q;
    assign JAMZ      = jamz_q;
    assign set_F     = setf_q;
    assign ins_fetch = fetch_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign state_o   = state_q;
    assign ir_o      = ir_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed and random programs checked cycle by cycle against a trace model.
module tb_alu_sequencer;

    localparam int MW = 3;
`ifdef SEQ_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] ins = 8'h00;
    logic       j_in = 1'b0;
    logic [4:0] C;
    logic [1:0] B, M;
    logic [3:0] ALU_sig;
    logic       JAMZ, set_F, ins_fetch, busy, halted, illegal;
    logic [2:0] state_o;
    logic [7:0] ir_o;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]  prog_q[$];
    logic        jin_q[$];
    logic [18:0] exp_q[$];
    int          fetch_at[$];

    alu_sequencer #(.MEM_WAIT(MW)) dut (
        .clk(clk), .rst(rst), .start(start), .ins(ins), .j_in(j_in),
        .C(C), .B(B), .M(M), .ALU_sig(ALU_sig), .JAMZ(JAMZ), .set_F(set_F),
        .ins_fetch(ins_fetch), .busy(busy), .halted(halted), .illegal(illegal),
        .state_o(state_o), .ir_o(ir_o)
    );

    always #5 clk = ~clk;

    // Observed vector layout: {C, B, M, ALU_sig, JAMZ, set_F, ins_fetch, busy, halted, illegal}
    function automatic logic [18:0] row(input logic [4:0] c, input logic [1:0] b, input logic [1:0] m,
                                        input logic [3:0] a, input logic jz, input logic sf,
                                        input logic fe, input logic bs, input logic hl, input logic il);
        return {c, b, m, a, jz, sf, fe, bs, hl, il};
    endfunction

    // Expected trace: every instruction is FETCH, DECODE, EXEC, then MW memory cycles for LDM/STM.
    function automatic void build_model();
        logic       ill;
        logic       bad;
        logic [3:0] op;
        logic [7:0] byte_v;
        logic [18:0] ex;
        ill = 1'b0;
        exp_q.delete();
        fetch_at.delete();
        for (int n = 0; n < prog_q.size(); n++) begin
            byte_v = prog_q[n];
            op = byte_v[7:4];
            fetch_at.push_back(exp_q.size());
            exp_q.push_back(row(5'b10000, 2'b00, 2'b00, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, ill));
            exp_q.push_back(row(5'b00000, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill));
            bad = (op >= 4'h9 && op <= 4'hE);
            if (bad) ill = 1'b1;
            case (op)
                4'h1, 4'h2: ex = row(5'b01000, 2'b11, 2'b00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill);
                4'h3:       ex = row(5'b00001, 2'b00, 2'b00, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ill);
                4'h4:       ex = row(5'b00001, 2'b00, 2'b00, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ill);
                4'h5:       ex = row(5'b00001, 2'b00, 2'b00, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ill);
                4'h6:       ex = row(5'b00010, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill);
                4'h7:       ex = row(5'b10000, 2'b11, 2'b00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill);
                4'h8:       ex = jin_q[n] ? row(5'b10000, 2'b11, 2'b00, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ill)
                                          : row(5'b00000, 2'b00, 2'b00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, ill);
                default:    ex = row(5'b00000, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill);
            endcase
            exp_q.push_back(ex);
            if (op == 4'h1 || op == 4'h2) begin
                for (int i = 0; i < MW; i++) begin
                    if (op == 4'h1 && i == MW - 1)
                        exp_q.push_back(row(5'b00001, 2'b10, 2'b10, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill));
                    else
                        exp_q.push_back(row(5'b00000, 2'b00, (op == 4'h1) ? 2'b10 : 2'b01, 4'd0,
                                            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ill));
                end
            end
            if (op == 4'hF || (TRAP && bad)) begin
                exp_q.push_back(row(5'b00000, 2'b00, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ill));
                return;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [18:0] expv);
        logic [18:0] obs;
        obs = {C, B, M, ALU_sig, JAMZ, set_F, ins_fetch, busy, halted, illegal};
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b required %b", tag, obs, expv);
        end
    endtask

    task automatic check_ir(input string tag, input logic [7:0] expv);
        n_assert++;
        assert (ir_o === expv) else begin
            n_fail++;
            $error("FAIL %s: ir observed %h required %h", tag, ir_o, expv);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("reset", 19'd0);
        check_ir("reset_ir", 8'h00);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_hold", 19'd0);
    endtask

    // abort_k >= 0 asserts rst during trace cycle abort_k instead of running to HALT
    task automatic run_prog(input int abort_k);
        int ni;
        logic [7:0] last_ins;
        ni = 0;
        build_model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (ni < fetch_at.size() && fetch_at[ni] == k) begin
                ins  = prog_q[ni];
                j_in = jin_q[ni];
                ni++;
            end
            if (k == abort_k) rst = 1'b1;
            @(negedge clk);
            check($sformatf("cyc%0d_ins%h", k, ins), exp_q[k]);
            if (ni > 0 && k == fetch_at[ni-1] + 2) begin
                last_ins = prog_q[ni-1];
                check_ir($sformatf("ir_cyc%0d", k), last_ins);
            end
            if (k == abort_k) break;
        end
        if (abort_k >= 0) begin
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            check("rst_mid_mem", 19'd0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1 start = 1'b1;
                @(negedge clk);
                check($sformatf("halt_hold%0d", i), exp_q[exp_q.size()-1]);
            end
            start = 1'b0;
        end
    endtask

    task automatic add_ins(input logic [7:0] b, input logic j);
        prog_q.push_back(b);
        jin_q.push_back(j);
    endtask

    initial begin
        logic [7:0] rb;

        do_reset();
        prog_q.delete(); jin_q.delete();
        add_ins(8'h35, 1'b0); add_ins(8'hF0, 1'b0);
        run_prog(-1);

        do_reset();
        prog_q.delete(); jin_q.delete();
        add_ins(8'h1A, 1'b0); add_ins(8'h84, 1'b1); add_ins(8'h84, 1'b0); add_ins(8'h2B, 1'b1);
        add_ins(8'h60, 1'b0); add_ins(8'h7F, 1'b0); add_ins(8'h43, 1'b1); add_ins(8'h52, 1'b0);
        add_ins(8'h00, 1'b1); add_ins(8'hC0, 1'b0); add_ins(8'h15, 1'b0); add_ins(8'hF0, 1'b0);
        run_prog(-1);

        do_reset();
        prog_q.delete(); jin_q.delete();
        add_ins(8'h1A, 1'b0);
        run_prog(4);
        @(posedge clk); #1;
        @(negedge clk);
        check("idle_after_abort", 19'd0);

        for (int p = 0; p < 10; p++) begin
            do_reset();
            prog_q.delete(); jin_q.delete();
            for (int i = 0; i < int'($urandom_range(4, 10)); i++) begin
                rb[7:4] = 4'($urandom_range(0, 14));
                rb[3:0] = 4'($urandom_range(0, 15));
                add_ins(rb, 1'($urandom_range(0, 1)));
            end
            add_ins(8'hF0, 1'b0);
            run_prog(-1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Hardwired control sequencer for the ALU/register datapath. Fetches an 8-bit instruction, decodes it, and drives the datapath control fields cycle by cycle: register write-enables `C`, B-bus select `B`, memory strobes `M`, ALU opcode `ALU_sig`, and flag controls `JAMZ`/`set_F`. Consumes the flag unit's jump result `j_in`. Sits between instruction memory and the datapath top level as the sole driver of its control inputs.

## Interface
- `MEM_WAIT`, 1: cycles the `M` strobe is held for a data-memory access (1..15).
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  leave IDLE and begin fetching; ignored outside IDLE.
- `ins`  in  8  instruction byte; valid the cycle after `ins_fetch`. Opcode is `ins[7:4]`, operand is `ins[3:0]`.
- `j_in`  in  1  jump condition from the flag unit; sampled in EXEC when `JAMZ`=1.
- `C`  out  5  one-hot register write-enable: bit0 AC, bit1 R1, bit2 R2, bit3 MAR, bit4 PC.
- `B`  out  2  B-bus select: 00 R1, 01 R2, 10 memory data, 11 instruction operand.
- `M`  out  2  memory strobes: `M[1]` read, `M[0]` write; 11 is never driven.
- `ALU_sig`  out  4  0 pass A, 1 add, 2 sub, 3 and, 4 pass B, 5 increment A.
- `JAMZ`  out  1  request a conditional jump on Z.
- `set_F`  out  1  latch the ALU Z result into the flag unit.
- `ins_fetch`  out  1  instruction-memory read strobe.
- `busy`  out  1  high in every state except IDLE and HALT.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on an undefined opcode.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: all outputs 0. `start` moves the FSM to FETCH.
- FETCH (1 cycle): `ins_fetch`=1; PC←PC+1 (`C`=10000, `ALU_sig`=5). Next state is DECODE.
- DECODE (1 cycle): IR←`ins`. Next state is EXEC.
- EXEC, by opcode:
  - 0 NOP: no action.
  - 1 LDM: MAR←operand (`C`=01000, `B`=11, `ALU_sig`=4), then MEM as a read; on the final MEM cycle AC←data (`B`=10, `C`=00001).
  - 2 STM: MAR←operand, then MEM as a write (`M`=01) on AC.
  - 3 ADD, 4 SUB, 5 AND: AC←AC op R1 (`B`=00, `C`=00001, `ALU_sig`=1/2/3, `set_F`=1).
  - 6 MOV: R1←AC (`C`=00010, `ALU_sig`=0).
  - 7 JMP: PC←operand (`C`=10000, `B`=11, `ALU_sig`=4).
  - 8 JZ: `JAMZ`=1. If `j_in`=1, do as JMP; otherwise no writes.
  - F HALT: go to HALT.
  - Any other opcode is illegal; handling is set under Configuration.
- After EXEC (or after MEM completes), the next state is FETCH.
- MEM: the `M` strobe is held for exactly `MEM_WAIT` cycles; `C` is 0 except on the final LDM cycle.
- HALT: all control outputs 0, `halted`=1. Only `rst` exits HALT.
- Outside its defining state, every control output is 0; at most one `C` bit is ever high.

## Timing
- `rst` returns to IDLE within the same edge: IR=0, `illegal`=0, all outputs 0. This applies in any state, including mid-MEM; the strobe drops the next cycle and no partial write-back occurs.
- Latency from FETCH to next FETCH:
  - 3 cycles for ALU, MOV, JMP, JZ and NOP.
  - 3+`MEM_WAIT` cycles for LDM and STM.
- `start` asserted in the same cycle as `rst` is ignored.
- PC wraps 0xFF→0x00; the ALU does this with no sequencer action.

## Configuration
- `SEQ_ILLEGAL_TRAP_EN` defined: an illegal opcode sets `illegal` in EXEC and goes to HALT the next cycle.
- Not defined: an illegal opcode sets `illegal` and executes as NOP; fetching continues.

## Test plan
- Reset during MEM of an LDM with `MEM_WAIT`=3 → the next cycle has `M`=00, `C`=0, state IDLE, `busy`=0.
- `start`, then `ins`=0x35 (ADD) → FETCH `C`=10000/`ALU_sig`=5; DECODE; EXEC `C`=00001, `B`=00, `ALU_sig`=1, `set_F`=1; FETCH again 3 cycles after the first.
- `ins`=0x1A (LDM 0xA), `MEM_WAIT`=2 → EXEC `C`=01000/`B`=11; 2 cycles of `M`=10, the second with `C`=00001/`B`=10; next FETCH at cycle 5.
- `ins`=0x84 (JZ) with `j_in`=1 → `JAMZ`=1, `C`=10000, `B`=11. Same with `j_in`=0 → `JAMZ`=1, `C`=0.
- `ins`=0xC0 (illegal) → `illegal`=1. With the macro: `halted`=1 the next cycle. Without it: FETCH follows.
- `ins`=0xF0 (HALT) → `halted`=1, `busy`=0; `start` is ignored; `rst` returns to IDLE.
